button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 99 +++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Four-button debouncer: 2-flop synchronizer, per-button stable-sample counter, press pulses and sticky event flags.
// Optional 8-bit per-button press counters are built when BUTTON_PRESS_COUNT_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        ipClk,
  input  logic        Reset,
  input  logic [3:0]  ipButtons,
  input  logic [3:0]  ipClearEvents,
  output logic [3:0]  opButtons,
  output logic [3:0]  opPressed,
  output logic [3:0]  opEvents
`ifdef BUTTON_PRESS_COUNT_EN
  ,
  output logic [31:0] opPressCount
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] sample;
  logic [3:0] toggle;

  // Synchronizer idles at 1 so a reset looks like "all buttons released".
  always_ff @(posedge ipClk) begin
    if (Reset) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= ipButtons;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = ~sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          differ;

      assign differ     = sample[gi] ^ opButtons[gi];
      assign toggle[gi] = differ && (cnt_reg == CNT_LAST);

      // Any cycle matching the accepted state restarts the count from zero.
      always_comb begin
        cnt_next = '0;
        if (differ && (cnt_reg != CNT_LAST)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge ipClk) begin
        if (Reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // Events are set from the registered pulse so a clear in the pulse cycle loses to the set.
  always_ff @(posedge ipClk) begin
    if (Reset) begin
      opButtons <= 4'h0;
      opPressed <= 4'h0;
      opEvents  <= 4'h0;
    end else begin
      opButtons <= opButtons ^ toggle;
      opPressed <= toggle & ~opButtons;
      opEvents  <= (opEvents & ~ipClearEvents) | opPressed;
    end
  end

`ifdef BUTTON_PRESS_COUNT_EN
  generate
    for (gi = 0; gi < 4; gi++) begin : g_press_count
      logic [7:0] count_reg;

      always_ff @(posedge ipClk) begin
        if (Reset) begin
          count_reg <= 8'h00;
        end else if (opPressed[gi]) begin
          count_reg <= count_reg + 8'h01;
        end
      end

      assign opPressCount[8*gi +: 8] = count_reg;
    end
  endgenerate
`endif

endmodule
